// File: rtl/code_conv_pkg.sv
// Shared mode encodings and elaboration helpers for the Gray/binary codec pipeline.
// Slices are assigned MSB-first, ceil(WIDTH/STAGES) bits each; trailing stages may own no bits.
package code_conv_pkg;

   localparam logic MODE_G2B = 1'b0;
   localparam logic MODE_B2G = 1'b1;

   function automatic logic popcount_is_one(input logic [63:0] vec);
      return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
   endfunction

   function automatic int slice_width(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   // A negative msb marks a stage whose slice lies entirely below bit 0.
   function automatic int slice_msb(input int k, input int width, input int stages);
      return width - 1 - k * slice_width(width, stages);
   endfunction

   function automatic int slice_lsb(input int k, input int width, input int stages);
      int lo;
      lo = slice_msb(k, width, stages) - slice_width(width, stages) + 1;
      return (lo < 0) ? 0 : lo;
   endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline register slice: resolves Gray bits [HI:LO] of a G2B word, passes B2G words through.
// Latency 1 cycle; captures on load, empties on drain, otherwise holds its word (stall-safe).
module gray_pipe_stage
   import code_conv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LO    = 0,
   parameter int HI    = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             drain,
   input  logic             src_mode,
   input  logic             src_err,
   input  logic [WIDTH-1:0] src_data,
   output logic             valid,
   output logic             mode,
   output logic             err,
   output logic [WIDTH-1:0] data
);

   // The running prefix is the binary bit just above this slice, already resolved
   // by the previous stage and carried in its data register; zero above the MSB.
   localparam int  SIDX      = (HI + 1 < 0) ? 0 : ((HI + 1 > WIDTH - 1) ? WIDTH - 1 : HI + 1);
   localparam bit  TOP_SLICE = (HI >= WIDTH - 1);

   logic             run;
   logic [WIDTH-1:0] resolved;

   always_comb begin
      run      = TOP_SLICE ? 1'b0 : src_data[SIDX];
      resolved = src_data;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i <= HI && i >= LO) begin
            run         = run ^ src_data[i];
            resolved[i] = run;
         end
      end
      if (src_mode == MODE_B2G) resolved = src_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         mode  <= 1'b0;
         err   <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         mode  <= src_mode;
         err   <= src_err;
         data  <= resolved;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/gray_binary_codec_pipe.sv
// Pipelined Gray<->binary converter with per-word mode and Gray adjacency checking.
// Latency STAGES cycles; bubble-collapsing ready chain, in_ready drops only when stage 0 is full and blocked.
module gray_binary_codec_pipe
   import code_conv_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_mode,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   logic [STAGES-1:0] stg_valid;
   logic [STAGES-1:0] advance;
   logic [STAGES-1:0] load;
   logic [STAGES:0]   next_free;
   logic [STAGES:0]   chain_mode;
   logic [STAGES:0]   chain_err;
   logic [WIDTH-1:0]  chain_data [STAGES+1];
   logic [WIDTH-1:0]  hist;
   logic              hist_valid;
   logic              accept;

   // next_free[k]: stage k can take a word this cycle (empty, or its word moves on).
   always_comb begin
      next_free         = '0;
      advance           = '0;
      load              = '0;
      next_free[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         advance[k]   = stg_valid[k] && next_free[k+1];
         next_free[k] = !stg_valid[k] || advance[k];
      end
      load[0] = in_valid && next_free[0];
      for (int k = 1; k < STAGES; k++) load[k] = advance[k-1];
   end

   assign in_ready = next_free[0];
   assign accept   = load[0];

   assign chain_mode[0] = in_mode;
   assign chain_data[0] = (in_mode == MODE_B2G) ? (in_data ^ (in_data >> 1)) : in_data;
   assign chain_err[0]  = (in_mode == MODE_G2B) && hist_valid &&
                          !popcount_is_one(64'(in_data ^ hist));

   // Any accepted B2G word breaks the Gray sequence, so the next G2B word restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist       <= '0;
         hist_valid <= 1'b0;
      end else if (accept) begin
         if (in_mode == MODE_G2B) begin
            hist       <= in_data;
            hist_valid <= 1'b1;
         end else begin
            hist_valid <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      gray_pipe_stage #(
         .WIDTH (WIDTH),
         .LO    (slice_lsb(k, WIDTH, STAGES)),
         .HI    (slice_msb(k, WIDTH, STAGES))
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load[k]),
         .drain    (advance[k]),
         .src_mode (chain_mode[k]),
         .src_err  (chain_err[k]),
         .src_data (chain_data[k]),
         .valid    (stg_valid[k]),
         .mode     (chain_mode[k+1]),
         .err      (chain_err[k+1]),
         .data     (chain_data[k+1])
      );
   end

   assign out_valid = stg_valid[STAGES-1];
   assign out_mode  = chain_mode[STAGES];
   assign out_err   = chain_err[STAGES];
   assign out_data  = chain_data[STAGES];

endmodule
